// File: rtl/cas_player.sv
// Cassette tape emulator: streams a .CAS byte image from memory as CoCo FSK audio,
// one 1200 Hz cycle per 0 bit and one 2400 Hz cycle per 1 bit, LSB first.
module cas_player #(
   parameter int ADDR_W    = 16,
   parameter int HALF0_CYC = 23863,
   parameter int HALF1_CYC = 11931
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              motor,
   input  logic              rewind,
   input  logic [ADDR_W-1:0] cas_len,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   input  logic              rd_valid,
   output logic              casdout,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(HALF0_CYC + 1);
   localparam logic [CW-1:0] H0_LAST = CW'(HALF0_CYC - 1);
   localparam logic [CW-1:0] H1_LAST = CW'(HALF1_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_HIGH,
      ST_LOW,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [7:0]        sr_q, sr_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     halfLast;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         len_q    <= '0;
         sr_q     <= '0;
         bitcnt_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         len_q    <= len_d;
         sr_q     <= sr_d;
         bitcnt_q <= bitcnt_d;
         cnt_q    <= cnt_d;
      end
   end

   // LOW reuses the half length of its HIGH because sr only shifts at the end of LOW.
   assign halfLast = sr_q[0] ? H1_LAST : H0_LAST;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      len_d    = len_q;
      sr_d     = sr_q;
      bitcnt_d = bitcnt_q;
      cnt_d    = cnt_q;
      if (rewind) begin
         state_d = ST_IDLE;
         ptr_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (motor) begin
                  if (cas_len == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     len_d   = cas_len;
                     state_d = ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               if (motor) state_d = ST_WAIT;
            end
            // Data already in flight is accepted even while paused; HIGH then holds.
            ST_WAIT: begin
               if (rd_valid) begin
                  sr_d     = rd_data;
                  bitcnt_d = '0;
                  ptr_d    = ptr_q + ADDR_W'(1);
                  cnt_d    = '0;
                  state_d  = ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (motor) begin
                  if (cnt_q == halfLast) begin
                     cnt_d   = '0;
                     state_d = ST_LOW;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            ST_LOW: begin
               if (motor) begin
                  if (cnt_q == halfLast) begin
                     cnt_d = '0;
                     if (bitcnt_q != 3'd7) begin
                        sr_d     = sr_q >> 1;
                        bitcnt_d = bitcnt_q + 3'd1;
                        state_d  = ST_HIGH;
                     end else if (ptr_q < len_q) begin
                        state_d = ST_FETCH;
                     end else begin
                        state_d = ST_DONE;
                     end
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_req  = (state_q == ST_FETCH) && motor && !rewind;
      rd_addr = ptr_q;
      casdout = (state_q == ST_HIGH);
      busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
      done    = (state_q == ST_DONE);
   end

endmodule
